// File: rtl/xpu_vpu_pc_tn_vlsu_nan_scan_ctrl_pkg.sv
// Shared types for the VLSU NaN scan sequencer.
// Element-width codes, FSM states and per-format field sizes.
package xpu_vpu_pc_tn_vlsu_nan_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      SEW_N = 2'b00,
      SEW_H = 2'b01,
      SEW_S = 2'b10,
      SEW_D = 2'b11
   } sew_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int SLICE_W = 64;

   localparam int H_EXP = 5;
   localparam int H_MAN = 10;
   localparam int S_EXP = 8;
   localparam int S_MAN = 23;
   localparam int D_EXP = 11;
   localparam int D_MAN = 52;

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_nan_scan_ctrl_if.sv
// Beat-in / result-out handshake bundle of the NaN scan sequencer.
interface xpu_vpu_pc_tn_vlsu_nan_scan_ctrl_if #(
   parameter int DATA_WIDTH = 128
);
   localparam int NELEM = DATA_WIDTH / 16;
   localparam int CW    = $clog2(NELEM) + 1;

   logic                  in_vld;
   logic                  in_rdy;
   logic [DATA_WIDTH-1:0] in_data;
   logic [1:0]            in_sew;
   logic [NELEM-1:0]      in_elem_mask;

   logic                  out_vld;
   logic                  out_rdy;
   logic [NELEM-1:0]      out_nan_mask;
   logic [CW-1:0]         out_nan_cnt;
   logic                  out_snan_any;

   modport master (
      output in_vld, in_data, in_sew, in_elem_mask, out_rdy,
      input  in_rdy, out_vld, out_nan_mask, out_nan_cnt,
      input  out_snan_any
   );

   modport slave (
      input  in_vld, in_data, in_sew, in_elem_mask, out_rdy,
      output in_rdy, out_vld, out_nan_mask, out_nan_cnt,
      output out_snan_any
   );
endinterface

// File: rtl/xpu_vpu_pc_tn_vlsu_ieee754_nan_type.sv
// IEEE-754 NaN / signalling-NaN classifier for one element.
// The sign bit is stripped by the caller since it never affects NaN-ness.
module xpu_vpu_pc_tn_vlsu_ieee754_nan_type #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic [EXP_W+MAN_W-1:0] val_i,
   output logic                   nan_o,
   output logic                   snan_o
);
   logic [EXP_W-1:0] exp;
   logic [MAN_W-1:0] man;

   assign exp    = val_i[EXP_W+MAN_W-1 -: EXP_W];
   assign man    = val_i[MAN_W-1:0];
   assign nan_o  = (&exp) & (|man);
   assign snan_o = nan_o & ~man[MAN_W-1];
endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_nan_scan_ctrl.sv
// Walks one vector beat in 64-bit slices and accumulates a per-element
// NaN mask, NaN count and signalling-NaN flag for the FP exception path.
module xpu_vpu_pc_tn_vlsu_nan_scan_ctrl
   import xpu_vpu_pc_tn_vlsu_nan_scan_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 128
) (
   input  logic cpuclk,
   input  logic cpurst_b,
   input  logic flush,
   xpu_vpu_pc_tn_vlsu_nan_scan_ctrl_if.slave bus
);
   localparam int NSLICE = DATA_WIDTH / SLICE_W;
   localparam int NELEM  = DATA_WIDTH / 16;
   localparam int CW     = $clog2(NELEM) + 1;
   localparam int CNTW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   sew_e                  sew_q, sew_d;
   logic [NELEM-1:0]      emask_q, emask_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic [NELEM-1:0]      nmask_q, nmask_d;
   logic [CW-1:0]         ncnt_q, ncnt_d;
   logic                  snan_q, snan_d;

   logic [DATA_WIDTH-1:0] sh;
   logic [63:0]           slice;
   logic [3:0]            h_nan, h_snan;
   logic [1:0]            s_nan, s_snan;
   logic                  d_nan, d_snan;
   logic [3:0]            loc_nan, loc_snan;
   logic [CNTW+1:0]       base;
   logic [NELEM-1:0]      new_nan, new_snan;
   logic [CW-1:0]         pc;
   logic                  last;

   assign sh    = data_q >> {cnt_q, 6'd0};
   assign slice = sh[63:0];
   assign last  = (cnt_q == CNTW'(NSLICE - 1));

   for (genvar g = 0; g < 4; g++) begin : g_h
      xpu_vpu_pc_tn_vlsu_ieee754_nan_type #(
         .EXP_W (H_EXP),
         .MAN_W (H_MAN)
      ) u_h (
         .val_i  (slice[16*g +: 15]),
         .nan_o  (h_nan[g]),
         .snan_o (h_snan[g])
      );
   end

   for (genvar g = 0; g < 2; g++) begin : g_s
      xpu_vpu_pc_tn_vlsu_ieee754_nan_type #(
         .EXP_W (S_EXP),
         .MAN_W (S_MAN)
      ) u_s (
         .val_i  (slice[32*g +: 31]),
         .nan_o  (s_nan[g]),
         .snan_o (s_snan[g])
      );
   end

   xpu_vpu_pc_tn_vlsu_ieee754_nan_type #(
      .EXP_W (D_EXP),
      .MAN_W (D_MAN)
   ) u_d (
      .val_i  (slice[62:0]),
      .nan_o  (d_nan),
      .snan_o (d_snan)
   );

   // Slice-local hits placed at cnt*(64/SEW); reserved SEW yields nothing.
   always_comb begin
      loc_nan  = '0;
      loc_snan = '0;
      base     = '0;
      unique case (sew_q)
         SEW_H: begin
            loc_nan  = h_nan;
            loc_snan = h_snan;
            base     = {cnt_q, 2'b00};
         end
         SEW_S: begin
            loc_nan  = {2'b00, s_nan};
            loc_snan = {2'b00, s_snan};
            base     = {1'b0, cnt_q, 1'b0};
         end
         SEW_D: begin
            loc_nan  = {3'b000, d_nan};
            loc_snan = {3'b000, d_snan};
            base     = {2'b00, cnt_q};
         end
         default: ;
      endcase
   end

   assign new_nan  = (NELEM'(loc_nan) << base) & emask_q;
   assign new_snan = (NELEM'(loc_snan) << base) & emask_q;

   always_comb begin
      pc = '0;
      for (int i = 0; i < NELEM; i++) begin
         pc = pc + CW'(new_nan[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sew_d   = sew_q;
      emask_d = emask_q;
      cnt_d   = cnt_q;
      nmask_d = nmask_q;
      ncnt_d  = ncnt_q;
      snan_d  = snan_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         nmask_d = '0;
         ncnt_d  = '0;
         snan_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_vld) begin
                  data_d  = bus.in_data;
                  sew_d   = sew_e'(bus.in_sew);
                  emask_d = bus.in_elem_mask;
                  cnt_d   = '0;
                  nmask_d = '0;
                  ncnt_d  = '0;
                  snan_d  = 1'b0;
                  state_d = SCAN;
               end
            end
            SCAN: begin
               nmask_d = nmask_q | new_nan;
               ncnt_d  = ncnt_q + pc;
               snan_d  = snan_q | (|new_snan);
               if (last) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_rdy) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q <= IDLE;
         data_q  <= '0;
         sew_q   <= SEW_N;
         emask_q <= '0;
         cnt_q   <= '0;
         nmask_q <= '0;
         ncnt_q  <= '0;
         snan_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sew_q   <= sew_d;
         emask_q <= emask_d;
         cnt_q   <= cnt_d;
         nmask_q <= nmask_d;
         ncnt_q  <= ncnt_d;
         snan_q  <= snan_d;
      end
   end

   assign bus.in_rdy       = (state_q == IDLE);
   assign bus.out_vld      = (state_q == DONE);
   assign bus.out_nan_mask = nmask_q;
   assign bus.out_nan_cnt  = ncnt_q;
   assign bus.out_snan_any = snan_q;
endmodule

// File: doc/xpu_vpu_pc_tn_vlsu_nan_scan_ctrl.md
# xpu_vpu_pc_tn_vlsu_nan_scan_ctrl

Sequencer in the VLSU floating-point load/store path that scans one accepted vector data beat for IEEE-754 NaNs at the current element width (fp16/fp32/fp64). It walks the beat in 64-bit slices, one slice per cycle, and sends each slice through a bank of NaN detectors. It accumulates a per-element NaN mask, a NaN count and a signalling-NaN summary, then returns the result over a valid/ready handshake. It sits between the VLSU data-merge stage and the FP exception/NaN-boxing logic.

## Interface
- DATA_WIDTH, 128, beat width in bits; must be a multiple of 64 and at least 64.
- NSLICE (derived), DATA_WIDTH/64, number of scan cycles.
- NELEM (derived), DATA_WIDTH/16, maximum element count at fp16.
- cpuclk  in  1  clock. One clock domain.
- cpurst_b  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort. Highest priority.
- in_vld  in  1  beat valid.
- in_rdy  out  1  beat ready. High only in IDLE.
- in_data  in  DATA_WIDTH  beat data, little-endian element packing.
- in_sew  in  2  element width: 01=fp16, 10=fp32, 11=fp64, 00=reserved.
- in_elem_mask  in  NELEM  bit i enables element i. Only bits [DATA_WIDTH/SEW-1:0] are used.
- out_vld  out  1  result valid.
- out_rdy  in  1  result accepted.
- out_nan_mask  out  NELEM  bit i set when enabled element i is NaN.
- out_nan_cnt  out  $clog2(NELEM)+1  popcount of out_nan_mask.
- out_snan_any  out  1  at least one enabled element is a signalling NaN (quiet bit = 0).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_rdy=1.
  - On in_vld: register data, sew and mask; clear the accumulators; clear slice counter cnt; go to SCAN.
- SCAN:
  - Each cycle, take slice cnt = data[64*cnt+63:64*cnt].
  - Classify the slice by sew: four fp16, two fp32 or one fp64 element.
  - Global element index = cnt*(64/SEW) + local index.
  - Gate each NaN result with the matching element-mask bit.
  - OR the results into the mask register.
  - Add the popcount of new NaN bits to the count.
  - OR any enabled sNaN into snan_any.
  - cnt==NSLICE-1: go to DONE. Otherwise cnt++.
- DONE:
  - out_vld=1. Outputs are held stable.
  - On out_rdy: go to IDLE. in_rdy rises the next cycle, so there is no same-cycle re-accept.
- sew=00: all elements are treated as absent. Mask, count and snan_any are 0. The full NSLICE scan latency still applies.
- NaN definition: exponent all-ones and mantissa nonzero.
  - A signalling NaN is a NaN whose mantissa MSB is 0.
  - Infinity is not NaN. Sign is ignored.
- flush in any state:
  - Next state is IDLE; out_vld drops the next cycle.
  - The beat is discarded; accumulators and cnt are cleared.
  - flush with in_vld in IDLE: the beat is not accepted.
- Reset values: state=IDLE, out_vld=0, in_rdy=1 (after reset deasserts), out_nan_mask=0, out_nan_cnt=0, out_snan_any=0, cnt=0.
- Reset mid-scan gives the same values immediately (asynchronous).

## Timing
- Accept edge T (in_vld & in_rdy).
- SCAN occupies cycles T+1 .. T+NSLICE.
- out_vld is high from cycle T+NSLICE+1. For DATA_WIDTH=128 this is 3 cycles after acceptance.
- Throughput: one beat per NSLICE+2 cycles with out_rdy held high.
- Outputs are registered. There are no combinational paths from in_* to out_*, and no path from out_rdy to in_rdy.
- Count width must hold NELEM without overflow.

## Structure
- Shared package holds:
  - SEW encodings: SEW_H=2'b01, SEW_S=2'b10, SEW_D=2'b11.
  - FSM state encodings.
  - Per-format exponent/mantissa sizes: 5/10, 8/23, 11/52.
- Sub-module: xpu_vpu_pc_tn_vlsu_ieee754_nan_type, instanced 7 times per slice (4×fp16, 2×fp32, 1×fp64).
  - sNaN detection is a separate mantissa-MSB test in this block.
- Single always-block FSM plus accumulator registers. No further hierarchy.

## Test plan
- fp32, data words {0x7FC00000, 0x3F800000, 0x7F800001, 0xFF800000}, mask 0x0F -> mask 0x05, cnt 2, snan_any 1; out_vld exactly 3 cycles after accept.
- fp16, all lanes 0x7E00, mask 0xAA -> mask 0xAA, cnt 4, snan_any 0.
- fp64, elements {0x7FF0000000000000, 0x7FF8000000000001}, mask 0x03 -> mask 0x02, cnt 1, snan_any 0 (infinity not counted).
- Backpressure: out_rdy low for 5 cycles in DONE -> outputs stable and in_rdy 0; next beat accepted no earlier than the cycle after the out handshake.
- flush in SCAN cycle 1 and cpurst_b low mid-SCAN -> IDLE, out_vld 0, in_rdy 1; the following beat produces a correct result with no residue.
- sew=00 with NaN data and mask 0xFF -> mask 0, cnt 0, snan_any 0, same 3-cycle latency.
